sr_cmd_debounce: RTL and testbench

Upstream command conditioner for the SR flip-flop stage. Takes two raw, asynchronous, bouncy request lines (set and reset, e.g. push-buttons) and turns them into clean single-cycle `s` / `r` pulses. The pulses are mutually exclusive and feed the flip-flop's `s` and `r` inputs directly. Each channel is synchronised and debounced independently. A final arbiter guarantees the SR-forbidden combination never reaches the flip-flop.

---
 rtl/sr_cmd_pkg.sv | 16 +
 rtl/sr_cmd_debounce_if.sv | 27 ++
 rtl/sr_debounce_ch.sv | 61 ++++++
 rtl/sr_cmd_debounce.sv | 65 ++++++
 tb/tb_sr_cmd_debounce.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command conditioner.
// Build option: SR_CMD_SYNC_EN enables the 2-flop input synchronisers.
package sr_cmd_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

   localparam int unsigned CH_SET   = 0;
   localparam int unsigned CH_RESET = 1;
   localparam int unsigned NUM_CH   = 2;

   typedef struct packed {
      logic db;
      logic rise;
   } ch_status_t;

endpackage

// File: rtl/sr_cmd_debounce_if.sv
// Request/command bundle between the raw request source and the SR conditioner.
// Build option: SR_CMD_SYNC_EN (affects only the conditioner's latency).
interface sr_cmd_debounce_if;

   logic set_raw;
   logic reset_raw;
   logic s;
   logic r;
   logic conflict;

   modport master (
      output set_raw,
      output reset_raw,
      input  s,
      input  r,
      input  conflict
   );

   modport slave (
      input  set_raw,
      input  reset_raw,
      output s,
      output r,
      output conflict
   );

endinterface

// File: rtl/sr_debounce_ch.sv
// One request channel: optional synchroniser, debounce counter, level and rise detect.
// Build option: SR_CMD_SYNC_EN inserts a 2-flop synchroniser ahead of the counter.
module sr_debounce_ch
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw,
   output ch_status_t status
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync;
   logic [CNT_W-1:0] cnt_q;
   logic             db_q;
   logic             db_prev_q;

`ifdef SR_CMD_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
      end
   end

   assign sync = sync_q[1];
`else
   assign sync = raw;
`endif

   // The level only moves after DEBOUNCE_CYCLES consecutive mismatches; any
   // agreeing cycle restarts the count, so the counter never passes CNT_MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         db_prev_q <= db_q;
         if (sync == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            db_q  <= sync;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign status.db   = db_q;
   assign status.rise = db_q & ~db_prev_q;

endmodule

// File: rtl/sr_cmd_debounce.sv
// Two debounced request channels arbitrated into mutually exclusive s/r pulses.
// Build option: SR_CMD_SYNC_EN adds input synchronisers (2 extra cycles of latency).
module sr_cmd_debounce
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input logic               clk,
   input logic               rst,
   sr_cmd_debounce_if.slave  bus
);

   ch_status_t status [NUM_CH];

   logic set_edge;
   logic reset_edge;
   logic s_q;
   logic r_q;
   logic conflict_q;

   sr_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch_set (
      .clk    (clk),
      .rst    (rst),
      .raw    (bus.set_raw),
      .status (status[CH_SET])
   );

   sr_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch_reset (
      .clk    (clk),
      .rst    (rst),
      .raw    (bus.reset_raw),
      .status (status[CH_RESET])
   );

   // A rise is only honoured while the debounced level is actually high.
   always_comb begin
      set_edge   = status[CH_SET].rise & status[CH_SET].db;
      reset_edge = status[CH_RESET].rise & status[CH_RESET].db;
   end

   // Reset wins a tie, so s and r can never be high together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         s_q        <= set_edge & ~reset_edge;
         r_q        <= reset_edge;
         conflict_q <= set_edge & reset_edge;
      end
   end

   assign bus.s        = s_q;
   assign bus.r        = r_q;
   assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Scoreboard bench for sr_cmd_debounce: directed scenarios plus random bouncy requests.
// Latency expectations follow SR_CMD_SYNC_EN when it is defined for the build.
module tb_sr_cmd_debounce;

   localparam int DC = 4;
`ifdef SR_CMD_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = DC + SYNC;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sr_cmd_debounce_if bus_if ();

   sr_cmd_debounce #(
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit s;
      bit r;
      bit c;
   } ev_t;

   ev_t exp_q[$];
   int  cyc          = 0;
   int  vectors      = 0;
   int  miscompares  = 0;
   int  s_cnt        = 0;
   int  c_cnt        = 0;
   int  last_s_cyc   = -1;
   int  last_r_cyc   = -1;
   int  last_c_cyc   = -1;

   // Reference model: per channel, the levels the debouncer sees, newest last.
   // A level is accepted once the last DC seen samples all disagree with it.
   bit samp [2][$];
   bit db_m [2];
   bit rise_pend [2];

   task automatic model_clear();
      for (int ch = 0; ch < 2; ch++) begin
         samp[ch].delete();
         for (int i = 0; i < SYNC + DC; i++) samp[ch].push_back(1'b0);
         db_m[ch]      = 1'b0;
         rise_pend[ch] = 1'b0;
      end
      exp_q.delete();
   endtask

   function automatic bit seen(int ch, int back);
      return samp[ch][samp[ch].size() - 1 - SYNC - back];
   endfunction

   always @(posedge rst) model_clear();

   always @(posedge clk) begin
      ev_t e;
      bit  raw;
      bit  all_diff;
      cyc = cyc + 1;
      if (rst) begin
         model_clear();
      end else begin
         e.cyc = cyc;
         e.s   = rise_pend[0] && !rise_pend[1];
         e.r   = rise_pend[1];
         e.c   = rise_pend[0] && rise_pend[1];
         if (e.s || e.r || e.c) exp_q.push_back(e);
         for (int ch = 0; ch < 2; ch++) begin
            raw = (ch == 0) ? bus_if.set_raw : bus_if.reset_raw;
            samp[ch].push_back(raw);
            void'(samp[ch].pop_front());
            all_diff = 1'b1;
            for (int b = 0; b < DC; b++) if (seen(ch, b) == db_m[ch]) all_diff = 1'b0;
            rise_pend[ch] = 1'b0;
            if (all_diff) begin
               rise_pend[ch] = !db_m[ch];
               db_m[ch]      = !db_m[ch];
            end
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT shows a pulse.
   always @(negedge clk) begin
      ev_t e;
      vectors++;
      if (bus_if.s && bus_if.r) begin
         miscompares++;
         $display("FAIL s_and_r cyc=%0d got s=1 r=1 required not both", cyc);
      end
      if (rst) begin
         vectors++;
         if (bus_if.s || bus_if.r || bus_if.conflict) begin
            miscompares++;
            $display("FAIL reset_outputs cyc=%0d got s=%0b r=%0b c=%0b required 0 0 0",
                     cyc, bus_if.s, bus_if.r, bus_if.conflict);
         end
      end else if (bus_if.s || bus_if.r || bus_if.conflict) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse cyc=%0d got s=%0b r=%0b c=%0b required none",
                     cyc, bus_if.s, bus_if.r, bus_if.conflict);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.s != bus_if.s || e.r != bus_if.r || e.c != bus_if.conflict) begin
               miscompares++;
               $display("FAIL pulse cyc=%0d got s=%0b r=%0b c=%0b required cyc=%0d s=%0b r=%0b c=%0b",
                        cyc, bus_if.s, bus_if.r, bus_if.conflict, e.cyc, e.s, e.r, e.c);
            end
         end
         if (bus_if.s) begin
            s_cnt++;
            last_s_cyc = cyc;
         end
         if (bus_if.r) last_r_cyc = cyc;
         if (bus_if.conflict) begin
            c_cnt++;
            last_c_cyc = cyc;
         end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_pulse cyc=%0d got none required cyc=%0d s=%0b r=%0b c=%0b",
                  cyc, e.cyc, e.s, e.r, e.c);
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check(string name, int got, int req);
      vectors++;
      if (got != req) begin
         miscompares++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   initial begin
      int c1;
      int s_before;
      int c_before;
      int hold_s;
      int hold_r;

      bus_if.set_raw   = 1'b1;
      bus_if.reset_raw = 1'b0;
      model_clear();

      // Set held through reset: one pulse once debounced from 0.
      tick(3);
      rst = 1'b0;
      c1  = cyc + 1;
      tick(15);
      check("reset_release_latency", last_s_cyc, c1 + LAT);
      check("reset_release_count", s_cnt, 1);
      bus_if.set_raw = 1'b0;
      tick(15);

      // Clean press held long: exactly one pulse.
      s_before = s_cnt;
      bus_if.set_raw = 1'b1;
      c1 = cyc + 1;
      tick(20);
      check("press_latency", last_s_cyc, c1 + LAT);
      check("press_single", s_cnt - s_before, 1);
      check("press_no_r", last_r_cyc, -1);
      bus_if.set_raw = 1'b0;
      tick(15);

      // Bounce on reset_raw, then settle high.
      for (int i = 0; i < 6; i++) begin
         bus_if.reset_raw = (i % 2 == 0);
         tick(2);
      end
      check("bounce_filtered", last_r_cyc, -1);
      bus_if.reset_raw = 1'b1;
      c1 = cyc + 1;
      tick(15);
      check("bounce_settle_latency", last_r_cyc, c1 + LAT);
      bus_if.reset_raw = 1'b0;
      tick(15);

      // Short glitch below the debounce length.
      s_before = s_cnt;
      bus_if.set_raw = 1'b1;
      tick(DC - 1);
      bus_if.set_raw = 1'b0;
      tick(15);
      check("glitch_filtered", s_cnt - s_before, 0);

      // Simultaneous rise: reset wins and conflict flags.
      s_before = s_cnt;
      c_before = c_cnt;
      bus_if.set_raw   = 1'b1;
      bus_if.reset_raw = 1'b1;
      c1 = cyc + 1;
      tick(15);
      check("simul_r_latency", last_r_cyc, c1 + LAT);
      check("simul_conflict_cyc", last_c_cyc, c1 + LAT);
      check("simul_conflict_count", c_cnt - c_before, 1);
      check("simul_no_s", s_cnt - s_before, 0);
      bus_if.set_raw   = 1'b0;
      bus_if.reset_raw = 1'b0;
      tick(15);

      // Reset mid-count: only the re-debounced press produces a pulse.
      s_before = s_cnt;
      bus_if.set_raw = 1'b1;
      tick(DC - 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      c1 = cyc + 1;
      tick(15);
      check("midcount_latency", last_s_cyc, c1 + LAT);
      check("midcount_single", s_cnt - s_before, 1);
      bus_if.set_raw = 1'b0;
      tick(15);

      // Random bouncy requests with occasional resets.
      hold_s = 1;
      hold_r = 1;
      for (int i = 0; i < 4000; i++) begin
         if (--hold_s == 0) begin
            bus_if.set_raw = ~bus_if.set_raw;
            hold_s = ($urandom_range(0, 2) == 0) ? $urandom_range(DC, 3 * DC) : $urandom_range(1, DC);
         end
         if (--hold_r == 0) begin
            bus_if.reset_raw = ~bus_if.reset_raw;
            hold_r = ($urandom_range(0, 2) == 0) ? $urandom_range(DC, 3 * DC) : $urandom_range(1, DC);
         end
         if ($urandom_range(0, 399) == 0) rst = 1'b1;
         else rst = 1'b0;
         tick(1);
      end
      rst = 1'b0;
      bus_if.set_raw   = 1'b0;
      bus_if.reset_raw = 1'b0;
      tick(30);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
